matrix_scan_driver: RTL and testbench
=====================================

// Module: matrix_scan_driver
// PURPOSE
//  Time-multiplexed driver for a ROWS x COLS LED matrix. Lights up to NPTS points.
//  Points are given as (row, col) coordinates.
//  Scans one column at a time. Row lines are active-low; column strobes are active-high one-hot.
//  A blanking gap sits between columns.
//  Sits between the game/controller logic (point coordinates) and the board pins.
// PARAMETERS
//  ROWS       7     number of row lines (row_n width)
//  COLS       5     number of columns scanned
//  NPTS       2     number of independently positioned points
//  DWELL      1000  clk cycles a column is driven (>=1)
//  BLANK_CYC  2     clk cycles all lines are off before each column (>=1)
//  RW/CW            derived: $clog2(ROWS), $clog2(COLS) (min 1)
// PORTS
//  clk          in   1         system clock, all state on rising edge
//  rst          in   1         asynchronous, active-high reset
//  en           in   1         scan enable; low = display dark
//  pt_row       in   NPTS*RW   row coordinate of point k at [k*RW +: RW]
//  pt_col       in   NPTS*CW   column coordinate of point k at [k*CW +: CW]
//  pt_vld       in   NPTS      point k is displayed when 1
//  row_n        out  ROWS      row drive, active-low (0 = LED on)
//  col          out  COLS      column strobe, one-hot or all-zero
//  frame_start  out  1         1-cycle pulse when column 0 blanking begins
//  busy         out  1         1 while FSM is not IDLE
// BEHAVIOUR
//  - Reset (async, any time):
//    - state=IDLE, col_idx=0, cnt=0
//    - row_n='1, col='0, frame_start=0, busy=0
//    - snapshot cleared (all invalid)
//  - All outputs are registered; no combinational path from inputs to pins.
//  - FSM states: IDLE, BLANK, DRIVE.
//    - IDLE: en=1 -> BLANK, col_idx=0, cnt=0, frame_start=1 on that edge.
//    - BLANK: row_n='1, col='0 for BLANK_CYC cycles.
//      On the first BLANK cycle of col 0, snapshot pt_* is taken.
//      Snapshot holds for the whole frame, so there is no tearing.
//      At cnt==BLANK_CYC-1 -> DRIVE, cnt=0.
//    - DRIVE: col[col_idx]=1 for DWELL cycles.
//      row_n[r]=0 iff some snapshot point k has vld & row==r & col==col_idx.
//      At cnt==DWELL-1 -> BLANK, cnt=0, col_idx advances.
//      Wrap: col_idx COLS-1 -> 0, and frame_start=1 on that transition.
//  - Frame period = COLS*(BLANK_CYC+DWELL) cycles; no gaps between frames.
//  - en deasserted in any state -> IDLE on the next edge, outputs dark that edge.
//    Re-enable always restarts at column 0 with a fresh snapshot.
//  - Coordinates out of range (row>=ROWS or col>=COLS) are ignored (no LED).
//  - Coincident points (same row/col) light one LED; no error.
//  - pt_* changes mid-frame take effect only at the next col-0 snapshot.
//  - Counters sized to max(DWELL,BLANK_CYC); cnt never exceeds terminal value.
// STRUCTURE
//  - Package matrix_pkg:
//    - state enum {IDLE, BLANK, DRIVE}
//    - width helper function (clog2 with min 1)
//    - default ROWS/COLS constants shared with the controller
//  - Sub-module matrix_col_decode (combinational):
//    - inputs: snapshot points, column index
//    - output: active-low ROWS-bit row pattern
//    - instantiated once; the FSM registers its output into row_n
// TESTING (ROWS=7, COLS=5, NPTS=2, DWELL=4, BLANK_CYC=1 unless noted)
//  1. rst=1 pulsed mid-DRIVE -> same cycle row_n=7'h7F, col=0, busy=0.
//     After release with en=0, outputs stay dark.
//  2. en=1, pts (r1,c0),(r2,c0) vld=11:
//     - frame_start at edge 1
//     - col=5'b00001 for 4 cycles with row_n=7'b1111001
//     - then col=0 for 1 cycle
//     - then col=5'b00010 with row_n=7'h7F
//  3. Free run 3 frames -> frame_start pulses exactly every 25 cycles.
//     col sequence is 1,2,4,8,16 with wrap to 1.
//  4. Change pt_row while col 2 is driven -> displayed pattern unchanged
//     until the next frame_start, then the new pattern appears.
//  5. pt (r7,c3) and (r3,c6), vld=11 -> row_n=7'h7F in every column.
//     pt vld=01 with the point at (r0,c4) -> only col 4 shows row_n=7'b1111110.
//  6. en dropped during BLANK of col 3 -> next cycle IDLE, dark.
//     Re-assert -> frame_start, then column 0 is driven first.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types, default geometry and width helper for the LED matrix scan driver
package matrix_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    localparam int ROWS_DEF = 7;
    localparam int COLS_DEF = 5;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_col_decode.sv
// matrix_col_decode: active-low row pattern for one column from a set of (row, col) points
module matrix_col_decode
    import matrix_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int NPTS = 2,
    parameter int RW   = clog2_min1(ROWS),
    parameter int CW   = clog2_min1(COLS)
) (
    input  logic [NPTS*RW-1:0] pt_row,
    input  logic [NPTS*CW-1:0] pt_col,
    input  logic [NPTS-1:0]    pt_vld,
    input  logic [CW-1:0]      col_idx,
    output logic [ROWS-1:0]    row_pat
);

    // col_idx is always a legal column, so a column match also rejects out-of-range columns;
    // out-of-range rows never match any r below ROWS
    always_comb begin
        row_pat = '1;
        for (int k = 0; k < NPTS; k++)
            for (int r = 0; r < ROWS; r++)
                if (pt_vld[k] && pt_row[k*RW +: RW] == RW'(r) && pt_col[k*CW +: CW] == col_idx)
                    row_pat[r] = 1'b0;
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: column-multiplexed LED matrix driver with per-frame point snapshot
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int NPTS      = 2,
    parameter int DWELL     = 1000,
    parameter int BLANK_CYC = 2,
    parameter int RW        = clog2_min1(ROWS),
    parameter int CW        = clog2_min1(COLS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NPTS*RW-1:0] pt_row,
    input  logic [NPTS*CW-1:0] pt_col,
    input  logic [NPTS-1:0]    pt_vld,
    output logic [ROWS-1:0]    row_n,
    output logic [COLS-1:0]    col,
    output logic               frame_start,
    output logic               busy
);

    localparam int CNTW = clog2_min1((DWELL > BLANK_CYC) ? DWELL : BLANK_CYC);
    localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL - 1);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]   COL_LAST   = CW'(COLS - 1);

    state_t              state, state_nxt;
    logic [CNTW-1:0]     cnt, cnt_nxt;
    logic [CW-1:0]       col_idx, idx_nxt;
    logic [NPTS*RW-1:0]  snap_row;
    logic [NPTS*CW-1:0]  snap_col;
    logic [NPTS-1:0]     snap_vld;
    logic [ROWS-1:0]     row_pat, row_nxt;
    logic [COLS-1:0]     col_nxt;
    logic                fs_nxt, busy_nxt;

    matrix_col_decode #(.ROWS(ROWS), .COLS(COLS), .NPTS(NPTS), .RW(RW), .CW(CW)) u_decode (
        .pt_row  (snap_row),
        .pt_col  (snap_col),
        .pt_vld  (snap_vld),
        .col_idx (idx_nxt),
        .row_pat (row_pat)
    );

    // state, counters and the frame snapshot; the snapshot is refreshed on every edge that starts column 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            col_idx  <= '0;
            snap_row <= '0;
            snap_col <= '0;
            snap_vld <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            col_idx <= idx_nxt;
            if (fs_nxt) begin
                snap_row <= pt_row;
                snap_col <= pt_col;
                snap_vld <= pt_vld;
            end
        end
    end

    // next-state: dropping en wins from any state; BLANK and DRIVE each count to their terminal value
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = col_idx;
        if (!en || state == IDLE) begin
            state_nxt = en ? BLANK : IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else if (state == BLANK) begin
            state_nxt = (cnt == BLANK_LAST) ? DRIVE : BLANK;
            cnt_nxt   = (cnt == BLANK_LAST) ? '0 : cnt + 1'b1;
        end else begin
            state_nxt = (cnt == DWELL_LAST) ? BLANK : DRIVE;
            cnt_nxt   = (cnt == DWELL_LAST) ? '0 : cnt + 1'b1;
            idx_nxt   = (cnt != DWELL_LAST) ? col_idx : (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
        end
    end

    // output values for the coming cycle, derived from the next state so the pins can be registered
    always_comb begin
        fs_nxt   = state_nxt == BLANK && state != BLANK && idx_nxt == '0;
        busy_nxt = state_nxt != IDLE;
        row_nxt  = (state_nxt == DRIVE) ? row_pat : '1;
        col_nxt  = (state_nxt == DRIVE) ? COLS'(1) << idx_nxt : '0;
    end

    // registered pins: dark and idle under reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_n       <= '1;
            col         <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            row_n       <= row_nxt;
            col         <= col_nxt;
            frame_start <= fs_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb_matrix_scan_driver: directed and randomized checks against a frame-position reference model
module tb_matrix_scan_driver;

    localparam int ROWS = 7, COLS = 5, NPTS = 2, DWELL = 4, BLANK = 1, RW = 3, CW = 3;
    localparam int SLOT = BLANK + DWELL;
    localparam int P = COLS * SLOT;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic [NPTS*RW-1:0] pt_row = '0;
    logic [NPTS*CW-1:0] pt_col = '0;
    logic [NPTS-1:0]    pt_vld = '0;
    logic [ROWS-1:0]    row_n;
    logic [COLS-1:0]    col;
    logic               frame_start;
    logic               busy;

    int vectors = 0;
    int errs = 0;
    bit run = 0;
    int m = 0;
    int cyc = 0;
    int last_fs = -1;
    logic [NPTS*RW-1:0] s_row = '0;
    logic [NPTS*CW-1:0] s_col = '0;
    logic [NPTS-1:0]    s_vld = '0;

    matrix_scan_driver #(.ROWS(ROWS), .COLS(COLS), .NPTS(NPTS), .DWELL(DWELL), .BLANK_CYC(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pt_row      (pt_row),
        .pt_col      (pt_col),
        .pt_vld      (pt_vld),
        .row_n       (row_n),
        .col         (col),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [ROWS-1:0] pat(input int c);
        logic [ROWS-1:0] p = '1;
        for (int k = 0; k < NPTS; k++) begin
            int r = int'(s_row[k*RW +: RW]);
            int cc = int'(s_col[k*CW +: CW]);
            if (s_vld[k] && r < ROWS && cc < COLS && cc == c) p[r] = 1'b0;
        end
        return p;
    endfunction

    function automatic bit in_drive();
        return run && (m % P) % SLOT >= BLANK;
    endfunction

    function automatic int cur_col();
        return (m % P) / SLOT;
    endfunction

    task automatic check();
        logic [ROWS-1:0] e_row = '1;
        logic [COLS-1:0] e_col = '0;
        logic            e_fs = 1'b0;
        if (run) begin
            e_fs = (m % P) == 0;
            if (in_drive()) begin
                e_col = COLS'(1) << cur_col();
                e_row = pat(cur_col());
            end
        end
        vectors++;
        assert (row_n === e_row) else begin errs++; $error("FAIL row_n obs=%b exp=%b m=%0d", row_n, e_row, m); end
        vectors++;
        assert (col === e_col) else begin errs++; $error("FAIL col obs=%b exp=%b m=%0d", col, e_col, m); end
        vectors++;
        assert (frame_start === e_fs) else begin errs++; $error("FAIL frame_start obs=%b exp=%b m=%0d", frame_start, e_fs, m); end
        vectors++;
        assert (busy === run) else begin errs++; $error("FAIL busy obs=%b exp=%b", busy, run); end
        if (frame_start === 1'b1 && run && last_fs >= 0) begin
            vectors++;
            assert (cyc - last_fs == P) else begin errs++; $error("FAIL fs_period obs=%0d exp=%0d", cyc - last_fs, P); end
        end
        if (!run) last_fs = -1;
        else if (frame_start === 1'b1) last_fs = cyc;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!en) run = 0;
        else begin
            m = run ? m + 1 : 0;
            run = 1;
            if (m % P == 0) begin
                s_row = pt_row;
                s_col = pt_col;
                s_vld = pt_vld;
            end
        end
        #1 check();
    endtask

    task automatic wait_pos(input int c, input bit drive);
        int n = 0;
        while (!(run && cur_col() == c && in_drive() == drive) && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        assert (n < 200) else begin errs++; $error("FAIL wait_pos timeout obs=%0d exp=<200", n); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check();
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        pt_row = {3'd2, 3'd1};
        pt_col = {3'd0, 3'd0};
        pt_vld = 2'b11;
        repeat (12) tick();
        wait_pos(1, 1);
        #2 rst = 1'b1;
        run = 0;
        #1 check();
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
        en = 1'b1;
        repeat (3 * P + 2) tick();
        wait_pos(2, 1);
        pt_row = {3'($urandom_range(0, 6)), 3'($urandom_range(0, 6))};
        pt_col = {3'd2, 3'd2};
        repeat (2 * P) tick();
        pt_row = {3'd3, 3'd7};
        pt_col = {3'd6, 3'd3};
        pt_vld = 2'b11;
        repeat (2 * P) tick();
        pt_row = {3'd5, 3'd0};
        pt_col = {3'd1, 3'd4};
        pt_vld = 2'b01;
        repeat (2 * P) tick();
        wait_pos(3, 0);
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (P + 3) tick();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                pt_row = NPTS*RW'($urandom);
                pt_col = NPTS*CW'($urandom_range(0, 63));
                pt_vld = NPTS'($urandom);
            end
            if ($urandom_range(0, 59) == 0) en = ~en;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
